// File: rtl/regwr_arbiter_if.sv
// Request/ready bundle for the two register-file writers: A (ALU writeback)
// and B (input loader).
interface regwr_arbiter_if #(
  parameter int N = 8
);
  logic         a_valid;
  logic [2:0]   a_addr;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [2:0]   b_addr;
  logic [N-1:0] b_data;
  logic         b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regwr_arbiter.sv
// Two-requester register-file write arbiter: A has default priority, B gets
// forced priority after MAXWAIT blocked cycles. Illegal addresses are dropped.
module regwr_arbiter #(
  parameter int N       = 8,
  parameter int MAXWAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  regwr_arbiter_if.slave   bus,
  output logic             write,
  output logic [2:0]       Waddr,
  output logic [N-1:0]     Wdata,
  output logic             err
);

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic [3:0]   wait_q, wait_d;
  logic         write_q, write_d;
  logic [2:0]   waddr_q, waddr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         err_q, err_d;

  logic         forced;
  logic         a_go, b_go;
  logic         xfer, legal;
  logic [2:0]   sel_addr;
  logic [N-1:0] sel_data;

  // Grant decision is combinational so a request can complete in the cycle it is raised.
  always_comb begin
    forced   = bus.b_valid && (wait_q == MAXW);
    a_go     = !reset && en && bus.a_valid && !forced;
    b_go     = !reset && en && bus.b_valid && (!bus.a_valid || forced);
    xfer     = a_go || b_go;
    sel_addr = b_go ? bus.b_addr : bus.a_addr;
    sel_data = b_go ? bus.b_data : bus.a_data;
    legal    = (sel_addr != 3'd0) && (sel_addr <= 3'd3);
  end

  assign bus.a_ready = a_go;
  assign bus.b_ready = b_go;

  always_comb begin
    write_d = xfer && legal;
    waddr_d = (xfer && legal) ? sel_addr : waddr_q;
    wdata_d = (xfer && legal) ? sel_data : wdata_q;
    err_d   = err_q || (xfer && !legal);
    // en=0 freezes the count, but a dropped B request always clears it.
    if (!bus.b_valid || b_go) begin
      wait_d = 4'd0;
    end else if (en && (wait_q != MAXW)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q  <= 4'd0;
      write_q <= 1'b0;
      waddr_q <= 3'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign write = write_q;
  assign Waddr = waddr_q;
  assign Wdata = wdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed bench for regwr_arbiter with hand-computed expectations and a
// small register-file model fed from the write port.
module tb_regwr_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         write;
  logic [2:0]   Waddr;
  logic [N-1:0] Wdata;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] rf [0:7];

  regwr_arbiter_if #(.N(N)) bus ();

  regwr_arbiter #(.N(N), .MAXWAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus),
    .write (write),
    .Waddr (Waddr),
    .Wdata (Wdata),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) rf[Waddr] <= Wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    reset = 1'b1;
    en    = 1'b1;
    drive(1'b1, 3'd2, 8'h33, 1'b0, 3'd0, 8'h00);
    cyc();
    // Reset overrides a concurrent request.
    chk("rst_a_ready", bus.a_ready, 1'b0);
    cyc();
    chk("rst_write", write, 1'b0);
    chk("rst_waddr", Waddr, 3'd0);
    chk("rst_wdata", Wdata, 8'h00);
    chk("rst_err",   err,   1'b0);

    // Single A write, first cycle out of reset.
    reset = 1'b0;
    drive(1'b1, 3'd2, 8'h15, 1'b0, 3'd0, 8'h00);
    chk("a1_a_ready", bus.a_ready, 1'b1);
    chk("a1_b_ready", bus.b_ready, 1'b0);
    cyc();
    chk("a1_write", write, 1'b1);
    chk("a1_waddr", Waddr, 3'd2);
    chk("a1_wdata", Wdata, 8'h15);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();
    chk("a1_idle_write", write, 1'b0);
    chk("a1_hold_waddr", Waddr, 3'd2);
    chk("a1_hold_wdata", Wdata, 8'h15);

    // Both valid continuously: A,A,A,B repeating, no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd1, 8'hA0 + 8'(i), 1'b1, 3'd2, 8'hB0 + 8'(i));
      chk($sformatf("fair_a_ready%0d", i), bus.a_ready, (i % 4) != 3);
      chk($sformatf("fair_b_ready%0d", i), bus.b_ready, (i % 4) == 3);
      cyc();
      chk($sformatf("fair_write%0d", i), write, 1'b1);
      chk($sformatf("fair_wdata%0d", i), Wdata, ((i % 4) == 3) ? 8'hB0 + 8'(i) : 8'hA0 + 8'(i));
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();

    // One blocked B cycle (count=1), then en=0 freezes it for 5 cycles.
    drive(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20);
    cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("en0_a_ready%0d", i), bus.a_ready, 1'b0);
      chk($sformatf("en0_b_ready%0d", i), bus.b_ready, 1'b0);
      cyc();
      chk($sformatf("en0_write%0d", i), write, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("en1_a_ready%0d", i), bus.a_ready, i != 2);
      chk($sformatf("en1_b_ready%0d", i), bus.b_ready, i == 2);
      cyc();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();

    // Same-address race: A then B, B's value lands last.
    drive(1'b1, 3'd3, 8'h01, 1'b1, 3'd3, 8'h02);
    chk("race_a_ready", bus.a_ready, 1'b1);
    cyc();
    chk("race_w1_data", Wdata, 8'h01);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h02);
    chk("race_b_ready", bus.b_ready, 1'b1);
    cyc();
    chk("race_w2_write", write, 1'b1);
    chk("race_w2_data", Wdata, 8'h02);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();
    chk("race_rf3", rf[3], 8'h02);

    // Data changes while not ready are ignored; the accepting edge samples.
    en = 1'b0;
    drive(1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 8'h00);
    cyc();
    en = 1'b1;
    drive(1'b1, 3'd1, 8'h88, 1'b0, 3'd0, 8'h00);
    cyc();
    chk("sample_wdata", Wdata, 8'h88);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();

    // Illegal addresses: handshake completes, no write, sticky err.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h99);
    chk("ill0_b_ready", bus.b_ready, 1'b1);
    cyc();
    chk("ill0_write", write, 1'b0);
    chk("ill0_err",   err,   1'b1);
    chk("ill0_waddr", Waddr, 3'd1);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h9A);
    chk("ill5_b_ready", bus.b_ready, 1'b1);
    cyc();
    chk("ill5_write", write, 1'b0);
    chk("ill5_wdata", Wdata, 8'h88);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();
    cyc();
    chk("ill_err_sticky", err, 1'b1);

    // Reset right after an A transfer discards the pending write.
    reset = 1'b1;
    cyc();
    chk("clr_err", err, 1'b0);
    reset = 1'b0;
    drive(1'b1, 3'd1, 8'h42, 1'b0, 3'd0, 8'h00);
    cyc();
    chk("pre_rst_write", write, 1'b1);
    reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc();
    chk("post_rst_write", write, 1'b0);
    chk("post_rst_waddr", Waddr, 3'd0);
    chk("post_rst_err",   err,   1'b0);
    reset = 1'b0;
    drive(1'b1, 3'd2, 8'h5A, 1'b1, 3'd1, 8'h6B);
    chk("first_grant_a", bus.a_ready, 1'b1);
    cyc();
    chk("first_grant_wdata", Wdata, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
